// File: rtl/mem_copy_engine_pkg.sv
// Shared types and default widths for the memory copy/fill engine.
package mem_copy_engine_pkg;

  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned LEN_W_DEF  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/mem_copy_engine_if.sv
// Single-port memory bus shared by the engine (master) and the memory (slave).
interface mem_copy_engine_if #(
  parameter int unsigned ADDR_W = mem_copy_engine_pkg::ADDR_W_DEF,
  parameter int unsigned DATA_W = mem_copy_engine_pkg::DATA_W_DEF
);
  logic [ADDR_W-1:0] mem_access_addr;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_write_en;
  logic              mem_read;
  logic [DATA_W-1:0] mem_read_data;

  modport master (
    output mem_access_addr, mem_write_data, mem_write_en, mem_read,
    input  mem_read_data
  );

  modport slave (
    input  mem_access_addr, mem_write_data, mem_write_en, mem_read,
    output mem_read_data
  );
endinterface

// File: rtl/mem_copy_engine.sv
// Word-at-a-time memory copy (RD/WR pairs) or fill (WR only) engine.
// All outputs are registered and computed from the next-state values.
module mem_copy_engine
  import mem_copy_engine_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic              abort,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] fill_data,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  words_done,
  mem_copy_engine_if.master mem
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_ptr_q, src_ptr_d;
  logic [ADDR_W-1:0] dst_ptr_q, dst_ptr_d;
  logic [LEN_W-1:0]  remain_q, remain_d;
  logic [LEN_W-1:0]  words_done_q, words_done_d;
  logic              mode_q, mode_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rd_q, rd_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      src_ptr_q    <= '0;
      dst_ptr_q    <= '0;
      remain_q     <= '0;
      words_done_q <= '0;
      mode_q       <= 1'b0;
      fill_q       <= '0;
      buf_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rd_q         <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      src_ptr_q    <= src_ptr_d;
      dst_ptr_q    <= dst_ptr_d;
      remain_q     <= remain_d;
      words_done_q <= words_done_d;
      mode_q       <= mode_d;
      fill_q       <= fill_d;
      buf_q        <= buf_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      rd_q         <= rd_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    src_ptr_d    = src_ptr_q;
    dst_ptr_d    = dst_ptr_q;
    remain_d     = remain_q;
    words_done_d = words_done_q;
    mode_d       = mode_q;
    fill_d       = fill_q;
    buf_d        = buf_q;

    unique case (state_q)
      ST_IDLE: begin
        // start together with abort is treated as not accepted
        if (start && !abort) begin
          src_ptr_d    = src_addr;
          dst_ptr_d    = dst_addr;
          remain_d     = len;
          mode_d       = mode;
          fill_d       = fill_data;
          words_done_d = '0;
          if (len == '0)  state_d = ST_DONE;
          else if (mode)  state_d = ST_WR;
          else            state_d = ST_RD;
        end
      end
      ST_RD: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          buf_d   = mem.mem_read_data;
          state_d = ST_WR;
        end
      end
      ST_WR: begin
        // the write strobed this cycle lands even on abort, but is not counted
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          src_ptr_d    = src_ptr_q + ADDR_W'(1);
          dst_ptr_d    = dst_ptr_q + ADDR_W'(1);
          words_done_d = words_done_q + LEN_W'(1);
          remain_d     = remain_q - LEN_W'(1);
          if (remain_q == LEN_W'(1)) state_d = ST_DONE;
          else if (mode_q)           state_d = ST_WR;
          else                       state_d = ST_RD;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
    rd_d    = (state_d == ST_RD);
    we_d    = (state_d == ST_WR);
    addr_d  = '0;
    wdata_d = '0;
    if (state_d == ST_RD) begin
      addr_d = src_ptr_d;
    end else if (state_d == ST_WR) begin
      addr_d  = dst_ptr_d;
      wdata_d = mode_d ? fill_d : buf_d;
    end
  end

  assign busy                = busy_q;
  assign done                = done_q;
  assign words_done          = words_done_q;
  assign mem.mem_read        = rd_q;
  assign mem.mem_write_en    = we_q;
  assign mem.mem_access_addr = addr_q;
  assign mem.mem_write_data  = wdata_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed self-checking bench for mem_copy_engine with a 64K-word memory model.
module tb_mem_copy_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        mode;
  logic        abort;
  logic [15:0] src_addr;
  logic [15:0] dst_addr;
  logic [15:0] len;
  logic [15:0] fill_data;
  logic        busy;
  logic        done;
  logic [15:0] words_done;

  logic        pre_we;
  logic [15:0] pre_addr;
  logic [15:0] pre_data;
  logic [15:0] mem [0:65535];

  logic [15:0] rd_addr [0:7];
  int          total;
  int          bad;

  mem_copy_engine_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  mem_copy_engine #(.ADDR_W(16), .DATA_W(16), .LEN_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .mode       (mode),
    .abort      (abort),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .len        (len),
    .fill_data  (fill_data),
    .busy       (busy),
    .done       (done),
    .words_done (words_done),
    .mem        (bus.master)
  );

  always #5 clk = ~clk;

  assign bus.mem_read_data = mem[bus.mem_access_addr];

  always @(posedge clk) begin
    if (pre_we)                mem[pre_addr] <= pre_data;
    else if (bus.mem_write_en) mem[bus.mem_access_addr] <= bus.mem_write_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  // One start edge, then scramble the inputs to prove they were latched
  task automatic issue(input logic m, input logic [15:0] s, input logic [15:0] d,
                       input logic [15:0] n, input logic [15:0] f);
    @(negedge clk);
    start = 1'b1; mode = m; src_addr = s; dst_addr = d; len = n; fill_data = f;
    @(posedge clk); #1;
    start = 1'b0; mode = ~m; src_addr = 16'h7777; dst_addr = 16'h7777;
    len = 16'd9; fill_data = 16'h5A5A;
  endtask

  // Sample cycles first_c..max_c after the start edge until done is seen
  task automatic watch(input int first_c, input int max_c,
                       output int done_c, output int rd_n, output int wr_n);
    done_c = -1; rd_n = 0; wr_n = 0;
    for (int c = first_c; c <= max_c; c++) begin
      @(negedge clk);
      check("rd_wr_exclusive", 32'(bus.mem_read & bus.mem_write_en), 32'd0);
      if (bus.mem_read) begin
        if (rd_n < 8) rd_addr[rd_n] = bus.mem_access_addr;
        rd_n++;
      end
      if (bus.mem_write_en) wr_n++;
      if (done) begin
        done_c = c;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc, rn, wn;
    bool_dummy: begin end
    total = 0; bad = 0;
    reset = 1'b1; start = 1'b0; mode = 1'b0; abort = 1'b0;
    src_addr = '0; dst_addr = '0; len = '0; fill_data = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    repeat (2) @(negedge clk);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    check("rst_wdone", 32'(words_done), 32'd0);
    check("rst_rd",    32'(bus.mem_read), 32'd0);
    check("rst_we",    32'(bus.mem_write_en), 32'd0);
    check("rst_addr",  32'(bus.mem_access_addr), 32'd0);
    reset = 1'b0;

    poke(16'd0, 16'h1111);
    poke(16'd1, 16'h2222);
    poke(16'd2, 16'h3333);

    // copy 0..2 -> 4..6
    issue(1'b0, 16'd0, 16'd4, 16'd3, 16'h0000);
    watch(1, 20, dc, rn, wn);
    check("copy_done_cycle", 32'(dc), 32'd7);
    check("copy_busy_in_done", 32'(busy), 32'd1);
    check("copy_rd_count", 32'(rn), 32'd3);
    check("copy_wr_count", 32'(wn), 32'd3);
    check("copy_wdone", 32'(words_done), 32'd3);
    check("copy_m4", 32'(mem[4]), 32'h1111);
    check("copy_m5", 32'(mem[5]), 32'h2222);
    check("copy_m6", 32'(mem[6]), 32'h3333);
    @(negedge clk);
    check("copy_idle_busy", 32'(busy), 32'd0);
    check("copy_idle_done", 32'(done), 32'd0);
    check("copy_wdone_hold", 32'(words_done), 32'd3);

    // fill 2..5 with A5A5
    issue(1'b1, 16'd0, 16'd2, 16'd4, 16'hA5A5);
    watch(1, 20, dc, rn, wn);
    check("fill_done_cycle", 32'(dc), 32'd5);
    check("fill_no_read", 32'(rn), 32'd0);
    check("fill_wr_count", 32'(wn), 32'd4);
    check("fill_wdone", 32'(words_done), 32'd4);
    check("fill_m2", 32'(mem[2]), 32'hA5A5);
    check("fill_m5", 32'(mem[5]), 32'hA5A5);
    check("fill_m6_untouched", 32'(mem[6]), 32'h3333);

    // zero length
    issue(1'b0, 16'd0, 16'd8, 16'd0, 16'h0000);
    watch(1, 10, dc, rn, wn);
    check("zero_done_cycle", 32'(dc), 32'd1);
    check("zero_rd", 32'(rn), 32'd0);
    check("zero_wr", 32'(wn), 32'd0);
    check("zero_wdone", 32'(words_done), 32'd0);

    // abort during the second RD (cycle 3)
    poke(16'h0021, 16'hDEAD);
    issue(1'b0, 16'd0, 16'h0020, 16'd3, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("abort_in_rd", 32'(bus.mem_read), 32'd1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_wdone", 32'(words_done), 32'd1);
    check("abort_m20", 32'(mem[16'h0020]), 32'h1111);
    check("abort_m21", 32'(mem[16'h0021]), 32'hDEAD);
    watch(5, 8, dc, rn, wn);
    check("abort_no_done", 32'(dc), 32'hFFFF_FFFF);

    // start together with abort in IDLE is not accepted
    @(negedge clk);
    start = 1'b1; abort = 1'b1; mode = 1'b1; dst_addr = 16'h0030; len = 16'd2;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("start_abort_idle", 32'(busy), 32'd0);

    // address wrap on the source pointer
    poke(16'hFFFF, 16'hBEEF);
    issue(1'b0, 16'hFFFF, 16'h0040, 16'd2, 16'h0000);
    watch(1, 20, dc, rn, wn);
    check("wrap_done_cycle", 32'(dc), 32'd5);
    check("wrap_rd0", 32'(rd_addr[0]), 32'hFFFF);
    check("wrap_rd1", 32'(rd_addr[1]), 32'h0000);
    check("wrap_m40", 32'(mem[16'h0040]), 32'hBEEF);
    check("wrap_m41", 32'(mem[16'h0041]), 32'h1111);

    // overlapping forward copy propagates the first word
    poke(16'h0080, 16'h0101);
    poke(16'h0081, 16'h0202);
    issue(1'b0, 16'h0080, 16'h0081, 16'd2, 16'h0000);
    watch(1, 20, dc, rn, wn);
    check("ovl_m81", 32'(mem[16'h0081]), 32'h0101);
    check("ovl_m82", 32'(mem[16'h0082]), 32'h0101);

    // second start while busy is ignored
    poke(16'h0060, 16'hCAFE);
    issue(1'b0, 16'd0, 16'h0050, 16'd3, 16'h0000);
    @(negedge clk);
    start = 1'b1; mode = 1'b1; dst_addr = 16'h0060; len = 16'd1; fill_data = 16'h7777;
    @(posedge clk); #1;
    start = 1'b0;
    watch(2, 20, dc, rn, wn);
    check("busy_done_cycle", 32'(dc), 32'd7);
    check("busy_wdone", 32'(words_done), 32'd3);
    check("busy_m50", 32'(mem[16'h0050]), 32'h1111);
    check("busy_m52", 32'(mem[16'h0052]), 32'hA5A5);
    check("busy_m60", 32'(mem[16'h0060]), 32'hCAFE);

    // asynchronous reset in the second WR cycle
    poke(16'h0071, 16'h0BAD);
    issue(1'b0, 16'd0, 16'h0070, 16'd3, 16'h0000);
    repeat (4) @(negedge clk);
    check("mid_we", 32'(bus.mem_write_en), 32'd1);
    check("mid_addr", 32'(bus.mem_access_addr), 32'h0071);
    reset = 1'b1;
    #1;
    check("arst_busy",  32'(busy), 32'd0);
    check("arst_wdone", 32'(words_done), 32'd0);
    check("arst_we",    32'(bus.mem_write_en), 32'd0);
    check("arst_rd",    32'(bus.mem_read), 32'd0);
    check("arst_addr",  32'(bus.mem_access_addr), 32'd0);
    check("arst_wdata", 32'(bus.mem_write_data), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    watch(1, 6, dc, rn, wn);
    check("arst_no_done", 32'(dc), 32'hFFFF_FFFF);
    check("arst_m70", 32'(mem[16'h0070]), 32'h1111);
    check("arst_m71", 32'(mem[16'h0071]), 32'h0BAD);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
